// File: rtl/lcd_timing_pkg.sv
// Shared panel constants and elaboration helpers for the LCD timing generator.
// Defaults describe the 480x272 RGB panel.
package lcd_timing_pkg;

    localparam int unsigned DefHActive = 480;
    localparam int unsigned DefHFront  = 2;
    localparam int unsigned DefHSync   = 41;
    localparam int unsigned DefHBack   = 2;
    localparam int unsigned DefVActive = 272;
    localparam int unsigned DefVFront  = 2;
    localparam int unsigned DefVSync   = 10;
    localparam int unsigned DefVBack   = 6;
    localparam int unsigned DefCw      = 10;

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return active + front + sync + back;
    endfunction

    // Never returns 0 so a degenerate axis still gets a 1-bit counter.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One wrapping timing axis: sync, back porch, active, front porch from count 0.
// Advances only on i_tick; o_wrap flags the tick that returns the count to 0.
module timing_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DefHActive,
    parameter int unsigned FRONT  = DefHFront,
    parameter int unsigned SYNC   = DefHSync,
    parameter int unsigned BACK   = DefHBack,
    parameter int unsigned CNT_W  = clog2_min1(axis_total(ACTIVE, FRONT, SYNC, BACK))
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap,
    output logic             o_in_sync,
    output logic             o_in_active
);

    localparam int unsigned Total    = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam int unsigned ActStart = SYNC + BACK;
    localparam int unsigned ActEnd   = SYNC + BACK + ACTIVE;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        o_wrap  = i_tick && (count_q == CNT_W'(Total - 1));
        count_d = count_q;
        if (o_wrap) begin
            count_d = '0;
        end else if (i_tick) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count     = count_q;
    assign o_in_sync   = count_q < CNT_W'(SYNC);
    assign o_in_active = (count_q >= CNT_W'(ActStart)) && (count_q < CNT_W'(ActEnd));

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/RGB-panel timing generator: registered syncs, data enable,
// active-area coordinates and line/frame markers, one clock behind the counters.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FRONT  = DefHFront,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BACK   = DefHBack,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FRONT  = DefVFront,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BACK   = DefVBack,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = DefCw
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_data_enable,
    output logic [CW-1:0] o_col,
    output logic [CW-1:0] o_row,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_vblank
);

    localparam int unsigned HTotal    = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned VTotal    = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HW        = clog2_min1(HTotal);
    localparam int unsigned VW        = clog2_min1(VTotal);
    localparam int unsigned HOff      = H_SYNC + H_BACK;
    localparam int unsigned VOff      = V_SYNC + V_BACK;
    localparam int unsigned MaxActive = (H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE;

    if ((64'd1 << CW) < 64'(MaxActive)) begin : g_cw_too_small
        $error("lcd_timing_gen: CW too narrow for the active area");
    end
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_porch_zero
        $error("lcd_timing_gen: porch and sync widths must be at least 1");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, h_sync, h_act;
    logic          v_sync, v_act;
    logic          unused_v_wrap;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .CNT_W  (HW)
    ) u_h_axis (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tick      (i_enable),
        .o_count     (h_cnt),
        .o_wrap      (h_wrap),
        .o_in_sync   (h_sync),
        .o_in_active (h_act)
    );

    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .CNT_W  (VW)
    ) u_v_axis (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tick      (h_wrap),
        .o_count     (v_cnt),
        .o_wrap      (unused_v_wrap),
        .o_in_sync   (v_sync),
        .o_in_active (v_act)
    );

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic          vblank_q, vblank_d;

    // While paused the level outputs freeze; the pulse-like outputs drop to 0.
    always_comb begin
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        vblank_d = vblank_q;
        col_d    = col_q;
        row_d    = row_q;
        de_d     = 1'b0;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        if (i_enable) begin
            hsync_d  = h_sync ? HS_POL : ~HS_POL;
            vsync_d  = v_sync ? VS_POL : ~VS_POL;
            vblank_d = ~v_act;
            de_d     = h_act & v_act;
            col_d    = de_d ? CW'(h_cnt - HW'(HOff)) : '0;
            row_d    = de_d ? CW'(v_cnt - VW'(VOff)) : '0;
            ls_d     = de_d && (h_cnt == HW'(HOff));
            fs_d     = ls_d && (v_cnt == VW'(VOff));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            de_q     <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            vblank_q <= 1'b1;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
            vblank_q <= vblank_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_data_enable = de_q;
    assign o_col         = col_q;
    assign o_row         = row_q;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;
    assign o_vblank      = vblank_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: default panel, a short active-high-sync
// panel for frame-level timing, and a tiny panel checked pixel by pixel.
module tb_lcd_timing_gen;

    logic clk;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Default 480x272 panel
    logic       d_rst = 1'b1, d_en = 1'b1;
    logic       d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
    logic [9:0] d_col, d_row;

    // H 20/2/3/2 (27), V 6/1/2/1 (10), active-high syncs
    logic       m_rst = 1'b1, m_en = 1'b1;
    logic       m_hs, m_vs, m_de, m_ls, m_fs, m_vb;
    logic [4:0] m_col, m_row;

    // H 4/1/2/1 (8), V 3/1/1/1 (6)
    logic       s_rst = 1'b1, s_en = 1'b1;
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_vb;
    logic [2:0] s_col, s_row;

    lcd_timing_gen dut (
        .i_clk         (clk),
        .i_rst         (d_rst),
        .i_enable      (d_en),
        .o_hsync       (d_hs),
        .o_vsync       (d_vs),
        .o_data_enable (d_de),
        .o_col         (d_col),
        .o_row         (d_row),
        .o_line_start  (d_ls),
        .o_frame_start (d_fs),
        .o_vblank      (d_vb)
    );

    lcd_timing_gen #(
        .H_ACTIVE (20), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (6),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CW (5)
    ) dut_mid (
        .i_clk         (clk),
        .i_rst         (m_rst),
        .i_enable      (m_en),
        .o_hsync       (m_hs),
        .o_vsync       (m_vs),
        .o_data_enable (m_de),
        .o_col         (m_col),
        .o_row         (m_row),
        .o_line_start  (m_ls),
        .o_frame_start (m_fs),
        .o_vblank      (m_vb)
    );

    lcd_timing_gen #(
        .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .CW       (3)
    ) dut_small (
        .i_clk         (clk),
        .i_rst         (s_rst),
        .i_enable      (s_en),
        .o_hsync       (s_hs),
        .o_vsync       (s_vs),
        .o_data_enable (s_de),
        .o_col         (s_col),
        .o_row         (s_row),
        .o_line_start  (s_ls),
        .o_frame_start (s_fs),
        .o_vblank      (s_vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_small_map();
        int          idx, h, v;
        logic        e_de, e_ls;
        logic [11:0] got, exp;
        s_rst = 1'b1;
        s_en  = 1'b1;
        repeat (3) tick();
        s_rst = 1'b0;
        // Two full frames plus a few pixels, across the (7,5) corner twice
        for (int k = 1; k <= 100; k++) begin
            tick();
            idx  = (k - 1) % 48;
            h    = idx % 8;
            v    = idx / 8;
            e_de = (h >= 3 && h <= 6 && v >= 2 && v <= 4);
            e_ls = e_de && (h == 3);
            exp  = {e_de, e_de ? 3'(h - 3) : 3'd0, e_de ? 3'(v - 2) : 3'd0,
                    (h >= 2), (v >= 1), !(v >= 2 && v <= 4), e_ls, e_ls && (v == 2)};
            got  = {s_de, s_col, s_row, s_hs, s_vs, s_vb, s_ls, s_fs};
            n_checks++;
            if (got !== exp)
                $display("FAIL small_map k=%0d h=%0d v=%0d: got %b want %b", k, h, v, got, exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_sync_pol();
        int errs, hs_err, hs_cnt, vs_err, de_cnt, fs_idx, idx;
        m_rst = 1'b1;
        m_en  = 1'b1;
        errs  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m_hs !== 1'b0 || m_vs !== 1'b0) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL pol_reset_syncs: got %0d bad cycles want 0", errs);
        else n_pass++;
        m_rst  = 1'b0;
        hs_err = 0; hs_cnt = 0; vs_err = 0; de_cnt = 0; fs_idx = -1;
        for (int k = 1; k <= 270; k++) begin
            tick();
            idx = k - 1;
            if (m_hs !== ((idx % 27) < 3)) hs_err++;
            if (m_hs === 1'b1) hs_cnt++;
            if (m_vs !== (idx < 54)) vs_err++;
            if (m_de === 1'b1) de_cnt++;
            if (m_fs === 1'b1) fs_idx = idx;
        end
        n_checks++;
        if (hs_err != 0) $display("FAIL pol_hsync_shape: got %0d bad cycles want 0", hs_err);
        else n_pass++;
        n_checks++;
        if (hs_cnt != 30) $display("FAIL pol_hsync_count: got %0d want 30", hs_cnt);
        else n_pass++;
        n_checks++;
        if (vs_err != 0) $display("FAIL pol_vsync_shape: got %0d bad cycles want 0", vs_err);
        else n_pass++;
        n_checks++;
        if (de_cnt != 120) $display("FAIL pol_de_count: got %0d want 120", de_cnt);
        else n_pass++;
        n_checks++;
        if (fs_idx != 86) $display("FAIL pol_frame_start_pos: got %0d want 86", fs_idx);
        else n_pass++;
    endtask

    task automatic test_frame_pause();
        int k;
        k = 0;
        do begin tick(); k++; end while (m_fs !== 1'b1 && k < 400);
        n_checks++;
        if (k != 87) $display("FAIL mid_next_frame_start: got %0d clocks want 87", k);
        else n_pass++;
        k = 0;
        do begin tick(); k++; end while (m_fs !== 1'b1 && k < 400);
        n_checks++;
        if (k != 270) $display("FAIL mid_frame_period: got %0d want 270", k);
        else n_pass++;
        repeat (50) tick();
        m_en = 1'b0;
        repeat (100) tick();
        m_en = 1'b1;
        k = 150;
        do begin tick(); k++; end while (m_fs !== 1'b1 && k < 700);
        n_checks++;
        if (k != 370) $display("FAIL mid_paused_period: got %0d want 370", k);
        else n_pass++;
    endtask

    task automatic test_reset();
        int k;
        d_rst = 1'b1;
        d_en  = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({d_de, d_ls, d_fs, d_hs, d_vs, d_vb} !== 6'b000111)
            $display("FAIL reset_ctrl: got %b want 000111", {d_de, d_ls, d_fs, d_hs, d_vs, d_vb});
        else n_pass++;
        n_checks++;
        if (d_col !== 10'd0 || d_row !== 10'd0)
            $display("FAIL reset_coords: got col %0d row %0d want 0 0", d_col, d_row);
        else n_pass++;
        d_rst = 1'b0;
        tick();
        k = 1;
        n_checks++;
        if (d_hs !== 1'b0 || d_vs !== 1'b0 || d_de !== 1'b0)
            $display("FAIL sync_after_release: got hs %b vs %b de %b want 0 0 0", d_hs, d_vs, d_de);
        else n_pass++;
        while (d_de !== 1'b1 && k < 9000) begin tick(); k++; end
        n_checks++;
        if (k != 8444) $display("FAIL first_de_clock: got %0d want 8444", k);
        else n_pass++;
        n_checks++;
        if ({d_fs, d_ls, d_col, d_row} !== {1'b1, 1'b1, 10'd0, 10'd0})
            $display("FAIL first_pixel: got fs %b ls %b col %0d row %0d want 1 1 0 0",
                     d_fs, d_ls, d_col, d_row);
        else n_pass++;
    endtask

    task automatic test_line();
        int errs, hs_cnt, ls_cnt;
        errs = 0;
        for (int i = 0; i < 480; i++) begin
            if (d_de !== 1'b1 || d_col !== 10'(i) || d_row !== 10'd0) errs++;
            tick();
        end
        n_checks++;
        if (errs != 0) $display("FAIL line_cols: got %0d bad pixels want 0", errs);
        else n_pass++;
        n_checks++;
        if (d_de !== 1'b0 || d_col !== 10'd0 || d_vb !== 1'b0)
            $display("FAIL front_porch: got de %b col %0d vb %b want 0 0 0", d_de, d_col, d_vb);
        else n_pass++;
        hs_cnt = 0;
        ls_cnt = 0;
        for (int i = 0; i < 525; i++) begin
            tick();
            if (d_hs === 1'b0) hs_cnt++;
            if (d_ls === 1'b1) ls_cnt++;
        end
        n_checks++;
        if (hs_cnt != 41) $display("FAIL hsync_width: got %0d want 41", hs_cnt);
        else n_pass++;
        n_checks++;
        if (ls_cnt != 1) $display("FAIL line_start_count: got %0d want 1", ls_cnt);
        else n_pass++;
    endtask

    task automatic test_pause();
        int k, errs;
        k = 0;
        while (!(d_de === 1'b1 && d_col === 10'd200 && d_row === 10'd5) && k < 20000) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 20000) $display("FAIL pause_reach: got timeout want pixel (200,5)");
        else n_pass++;
        d_en = 1'b0;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (d_de !== 1'b0 || d_ls !== 1'b0 || d_fs !== 1'b0 || d_col !== 10'd200 ||
                d_row !== 10'd5 || d_vb !== 1'b0 || d_hs !== 1'b1) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL pause_hold: got %0d bad cycles want 0", errs);
        else n_pass++;
        d_en = 1'b1;
        tick();
        n_checks++;
        if (d_de !== 1'b1 || d_col !== 10'd201 || d_row !== 10'd5)
            $display("FAIL pause_resume: got de %b col %0d row %0d want 1 201 5", d_de, d_col, d_row);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        while (!(d_de === 1'b1 && d_row === 10'd100) && k < 60000) begin tick(); k++; end
        n_checks++;
        if (k >= 60000) $display("FAIL mid_reset_reach: got timeout want row 100");
        else n_pass++;
        d_rst = 1'b1;
        tick();
        n_checks++;
        if ({d_de, d_ls, d_fs, d_hs, d_vs, d_vb, d_col, d_row} !== {6'b000111, 20'd0})
            $display("FAIL mid_reset_values: got %b want %b",
                     {d_de, d_ls, d_fs, d_hs, d_vs, d_vb, d_col, d_row}, {6'b000111, 20'd0});
        else n_pass++;
        d_rst = 1'b0;
        k = 0;
        while (d_de !== 1'b1 && k < 9000) begin tick(); k++; end
        n_checks++;
        if (k != 8444 || d_fs !== 1'b1)
            $display("FAIL mid_reset_first_de: got %0d clocks fs %b want 8444 1", k, d_fs);
        else n_pass++;
    endtask

    initial begin
        test_small_map();
        test_sync_pol();
        test_frame_pause();
        test_reset();
        test_line();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Parametrised LCD/RGB-panel timing generator. It is the successor to the fixed 480x272 data-enable counter. It produces registered hsync, vsync and data-enable, active-area pixel coordinates, and line/frame markers. Every porch, sync width and sync polarity is set by parameters. Sits between the pixel-clock domain and the pixel renderer (pong playfield, sprites) and drives the panel pins directly.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_FRONT, 2, horizontal front porch (clocks)
H_SYNC, 41, hsync pulse width (clocks)
H_BACK, 2, horizontal back porch (clocks)
V_ACTIVE, 272, visible lines per frame
V_FRONT, 2, vertical front porch (lines)
V_SYNC, 10, vsync pulse width (lines)
V_BACK, 6, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CW, 10, width of o_col/o_row

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  synchronous reset, active-high
i_enable  in  1  run/pause; low freezes timing
o_hsync  out  1  horizontal sync, polarity per HS_POL
o_vsync  out  1  vertical sync, polarity per VS_POL
o_data_enable  out  1  high on active pixels only
o_col  out  CW  active pixel column, 0..H_ACTIVE-1
o_row  out  CW  active pixel row, 0..V_ACTIVE-1
o_line_start  out  1  1-cycle pulse on the first active pixel of each active line
o_frame_start  out  1  1-cycle pulse on pixel (0,0) of each frame
o_vblank  out  1  high on all lines outside V_ACTIVE

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (default 525). V_TOTAL likewise (default 290).
- Internal counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1. Widths are clog2 of the respective totals.
- Segment order per line, from h_cnt=0: sync, back porch, active, front porch. Vertical order is the same.
- Active region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1]. Default is h 43..522, v 16..287.
- Counter update, when i_enable=1:
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - Both counters wrap together at (H_TOTAL-1, V_TOTAL-1).
- When i_enable=0: counters hold; o_data_enable, o_line_start and o_frame_start are forced 0; o_hsync, o_vsync, o_vblank, o_col and o_row hold their last values. When i_enable returns high, the counters resume from the held position with no skipped or repeated pixel.
- All outputs are registered. Latency is 1 clock: outputs in cycle N decode the counter state of cycle N-1.
- o_col = h_cnt-(H_SYNC+H_BACK) and o_row = v_cnt-(V_SYNC+V_BACK), zero-extended to CW, inside the active region. Both are 0 outside it.
- o_hsync is at the active level while h_cnt < H_SYNC. o_vsync is at the active level while v_cnt < V_SYNC, for whole lines.
- o_line_start is asserted when o_data_enable rises, i.e. col 0 of an active row. o_frame_start is that same cycle on row 0 only.
- Reset, synchronous:
  - h_cnt=0, v_cnt=0.
  - o_data_enable, o_line_start, o_frame_start = 0; o_col, o_row = 0.
  - o_hsync and o_vsync at their inactive levels (~HS_POL, ~VS_POL); o_vblank = 1.
  - Reset asserted mid-frame aborts the frame immediately. In the first cycle after release the counters are (0,0) and outputs still show reset values. The cycle after that shows sync active.
- Elaboration checks:
  - 2^CW >= max(H_ACTIVE, V_ACTIVE).
  - Every porch and sync parameter >= 1.
  - Elaboration fails otherwise.

Decomposition:
- Package lcd_timing_pkg holds:
  - the default 480x272 panel constants;
  - a H_TOTAL/V_TOTAL helper function;
  - a clog2 helper.
- One natural sub-module, timing_axis_counter: a single wrapping counter with parameters ACTIVE, FRONT, SYNC, BACK and inputs i_clk, i_rst, i_tick. It outputs count, wrap, in_sync and in_active. It is instantiated twice; the horizontal wrap drives the vertical i_tick.

Test Plan:
- Reset release, defaults, i_enable=1 -> first o_data_enable=1 at clock 8444 after release (counter at 16*525+43=8443). o_frame_start=1 and o_line_start=1 in that cycle, with o_col=0 and o_row=0.
- Free run over 2 frames -> o_frame_start period is exactly 152250 clocks. Per frame, DE-high count is 130560 and hsync-active count is 290*41. Per line, o_col runs 0..479 contiguously.
- Sync check with HS_POL=1, VS_POL=1 -> o_hsync high for 41 clocks per line. o_vsync high for 10*525 clocks starting at frame wrap. Both are 0 throughout reset.
- i_enable low for 100 clocks at o_col=200, o_row=5 -> DE is 0 throughout; on resume the next DE pixel is col 201, row 5. Frame period grows by exactly 100.
- i_rst pulsed for 1 clock mid-active (row 100) -> next cycle outputs equal reset values. The following frame's first DE arrives 8444 clocks after reset deassertion.
- Small config (H 4/1/2/1, V 3/1/1/1, CW=3) -> H_TOTAL=8, V_TOTAL=6. The full DE map matches the reference model cycle-exactly, including the corner wrap at (7,5).
